// File: rtl/pipe_hazard_sched.sv
// Stall/flush scheduler for a 5-stage MIPS pipeline: memory wait > branch flush > load-use.
// Define HAZ_PERF_CNT_EN to build the saturating o_stall_cycles counter.
module pipe_hazard_sched #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_mem_read,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_branch_taken,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_bubble,
`ifdef HAZ_PERF_CNT_EN
    output logic             o_timeout_err,
    output logic [CNT_W-1:0] o_stall_cycles
`else
    output logic             o_timeout_err
`endif
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1)
    begin : g_bad_param
        $error("pipe_hazard_sched: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_FLUSH
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;
    logic [2:0] r_flush_cnt;
    logic [2:0] w_flush_cnt_nxt;
    logic       r_timeout_err;
    logic       w_timeout_set;
    logic       w_mem_stall;
    logic       w_load_use;

    assign w_mem_stall = i_dmem_req && !i_dmem_ack;
    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_load_use  = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                         ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= 8'd0;
            r_flush_cnt   <= 3'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        w_timeout_set   = 1'b0;
        o_pc_en         = 1'b1;
        o_if_id_en      = 1'b1;
        o_ex_mem_en     = 1'b1;
        o_if_id_flush   = 1'b0;
        o_id_ex_flush   = 1'b0;
        o_mem_wb_bubble = 1'b0;

        case (r_state)
            S_RUN: begin
                if (w_mem_stall) begin
                    o_pc_en         = 1'b0;
                    o_if_id_en      = 1'b0;
                    o_ex_mem_en     = 1'b0;
                    o_mem_wb_bubble = 1'b1;
                    w_wait_cnt_nxt  = 8'd0;
                    w_state_nxt     = S_MEM_WAIT;
                end else if (i_branch_taken) begin
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_flush_cnt_nxt = FLUSH_INIT;
                        w_state_nxt     = S_FLUSH;
                    end
                end else if (w_load_use) begin
                    o_pc_en       = 1'b0;
                    o_if_id_en    = 1'b0;
                    o_id_ex_flush = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (i_dmem_ack) begin
                    w_wait_cnt_nxt = 8'd0;
                    w_state_nxt    = S_RUN;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    // forced release: the pipeline resumes as if the access had completed
                    w_timeout_set  = 1'b1;
                    w_wait_cnt_nxt = 8'd0;
                    w_state_nxt    = S_RUN;
                end else begin
                    o_pc_en         = 1'b0;
                    o_if_id_en      = 1'b0;
                    o_ex_mem_en     = 1'b0;
                    o_mem_wb_bubble = 1'b1;
                    w_wait_cnt_nxt  = r_wait_cnt + 8'd1;
                end
            end
            S_FLUSH: begin
                if (w_mem_stall) begin
                    o_pc_en         = 1'b0;
                    o_if_id_en      = 1'b0;
                    o_ex_mem_en     = 1'b0;
                    o_mem_wb_bubble = 1'b1;
                    w_wait_cnt_nxt  = 8'd0;
                    w_flush_cnt_nxt = 3'd0;
                    w_state_nxt     = S_MEM_WAIT;
                end else begin
                    o_if_id_flush = 1'b1;
                    if (r_flush_cnt <= 3'd1) begin
                        w_flush_cnt_nxt = 3'd0;
                        w_state_nxt     = S_RUN;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase

        // pipeline is held completely still while reset is asserted
        if (i_rst) begin
            o_pc_en         = 1'b0;
            o_if_id_en      = 1'b0;
            o_ex_mem_en     = 1'b0;
            o_if_id_flush   = 1'b0;
            o_id_ex_flush   = 1'b0;
            o_mem_wb_bubble = 1'b0;
        end
    end

    assign o_timeout_err = r_timeout_err;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (!o_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Self-checking bench for pipe_hazard_sched: directed scenarios plus randomized run vs a behavioural model.
`timescale 1ns/1ps
module tb_pipe_hazard_sched;

    localparam int FC = 3;
    localparam int MT = 15;
    localparam int CW = 4;

    // expected {pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble}
    localparam logic [5:0] P_NORM = 6'b111000;
    localparam logic [5:0] P_LU   = 6'b001010;
    localparam logic [5:0] P_BR   = 6'b111110;
    localparam logic [5:0] P_FL   = 6'b111100;
    localparam logic [5:0] P_FRZ  = 6'b000001;
    localparam logic [5:0] P_OFF  = 6'b000000;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       ack;
        logic [5:0] expo;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rd = 5'd0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0;
    logic       dmem_req = 1'b0, dmem_ack = 1'b0;
    logic       pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_bubble, timeout_err;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_sched #(
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_uses_rt   (id_uses_rt),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_rd        (ex_rd),
        .i_branch_taken (branch_taken),
        .i_dmem_req     (dmem_req),
        .i_dmem_ack     (dmem_ack),
        .o_pc_en        (pc_en),
        .o_if_id_en     (if_id_en),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_en    (ex_mem_en),
        .o_mem_wb_bubble(mem_wb_bubble),
`ifdef HAZ_PERF_CNT_EN
        .o_timeout_err  (timeout_err),
        .o_stall_cycles (stall_cycles)
`else
        .o_timeout_err  (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble};
    endfunction

    function automatic step_t mk(input int rs, input int rt, input bit urt, input bit mr, input int rd,
                                 input bit br, input bit req, input bit ack, input logic [5:0] e);
        step_t s;
        s.rs = 5'(rs); s.rt = 5'(rt); s.urt = urt; s.mr = mr; s.rd = 5'(rd);
        s.br = br; s.req = req; s.ack = ack; s.expo = e;
        return s;
    endfunction

    task automatic drive(input step_t s);
        id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt; ex_mem_read = s.mr; ex_rd = s.rd;
        branch_taken = s.br; dmem_req = s.req; dmem_ack = s.ack;
    endtask

    task automatic test_reset();
        drive(mk(5, 5, 1, 1, 5, 1, 1, 0, P_OFF));
        rst = 1'b1;
        #2;
        n_cmp++;
        if (obs() !== P_OFF) begin n_bad++; $display("FAIL reset_outputs: got %b want %b", obs(), P_OFF); end
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, P_NORM));
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== P_NORM) begin n_bad++; $display("FAIL reset_release_run: got %b want %b", obs(), P_NORM); end
`ifdef HAZ_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== '0) begin n_bad++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
`endif
    endtask

    task automatic test_load_use();
        step_t t[7];
        t[0] = mk(5, 0, 0, 1, 5, 0, 0, 0, P_LU);
        t[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, P_NORM);
        t[2] = mk(0, 0, 1, 1, 0, 0, 0, 0, P_NORM);
        t[3] = mk(3, 7, 0, 1, 7, 0, 0, 0, P_NORM);
        t[4] = mk(3, 7, 1, 1, 7, 0, 0, 0, P_LU);
        t[5] = mk(5, 0, 0, 0, 5, 0, 0, 0, P_NORM);
        t[6] = mk(9, 4, 1, 1, 12, 0, 0, 0, P_NORM);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(t[i]);
            #1;
            n_cmp++;
            if (obs() !== t[i].expo) begin
                n_bad++; $display("FAIL load_use step %0d: got %b want %b", i, obs(), t[i].expo);
            end
        end
    endtask

    task automatic test_branch_flush();
        step_t t[8];
        t[0] = mk(5, 0, 0, 1, 5, 1, 0, 0, P_BR);
        t[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, P_FL);
        t[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, P_FL);
        t[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, P_NORM);
        t[4] = mk(0, 0, 0, 0, 0, 1, 0, 0, P_BR);
        t[5] = mk(0, 0, 0, 0, 0, 0, 1, 0, P_FRZ);
        t[6] = mk(0, 0, 0, 0, 0, 0, 1, 1, P_NORM);
        t[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, P_NORM);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(t[i]);
            #1;
            n_cmp++;
            if (obs() !== t[i].expo) begin
                n_bad++; $display("FAIL branch_flush step %0d: got %b want %b", i, obs(), t[i].expo);
            end
        end
    endtask

    task automatic test_mem_wait();
        step_t t[7];
        t[0] = mk(0, 0, 0, 0, 0, 0, 1, 1, P_NORM);
        t[1] = mk(5, 0, 0, 1, 5, 1, 1, 0, P_FRZ);
        t[2] = mk(0, 0, 0, 0, 0, 0, 1, 0, P_FRZ);
        t[3] = mk(0, 0, 0, 0, 0, 0, 1, 0, P_FRZ);
        t[4] = mk(0, 0, 0, 0, 0, 0, 1, 0, P_FRZ);
        t[5] = mk(0, 0, 0, 0, 0, 0, 1, 1, P_NORM);
        t[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, P_NORM);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(t[i]);
            #1;
            n_cmp++;
            if (obs() !== t[i].expo) begin
                n_bad++; $display("FAIL mem_wait step %0d: got %b want %b", i, obs(), t[i].expo);
            end
        end
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL mem_wait_no_timeout: got %b want 0", timeout_err); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < MT; i++) begin
            @(negedge clk);
            drive(mk(0, 0, 0, 0, 0, 0, 1, 0, P_FRZ));
            #1;
            n_cmp++;
            if (obs() !== P_FRZ || timeout_err !== 1'b0) begin
                n_bad++; $display("FAIL timeout_frozen cycle %0d: got %b/%b want %b/0", i, obs(), timeout_err, P_FRZ);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs() !== P_NORM) begin n_bad++; $display("FAIL timeout_release: got %b want %b", obs(), P_NORM); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, P_NORM));
            #1;
            n_cmp++;
            if (obs() !== P_NORM || timeout_err !== 1'b1) begin
                n_bad++; $display("FAIL timeout_sticky cycle %0d: got %b/%b want %b/1", i, obs(), timeout_err, P_NORM);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, P_FRZ));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== P_OFF || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL mid_stall_reset: got %b/%b want %b/0", obs(), timeout_err, P_OFF);
        end
`ifdef HAZ_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== '0) begin n_bad++; $display("FAIL mid_stall_cnt_clear: got %0d want 0", stall_cycles); end
`endif
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, P_NORM));
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== P_NORM) begin n_bad++; $display("FAIL mid_stall_back_to_run: got %b want %b", obs(), P_NORM); end
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 1, 0, 0, P_BR));
        #2 rst = 1'b1;
        #1;
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, P_NORM));
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== P_NORM) begin n_bad++; $display("FAIL flush_dropped_by_reset: got %b want %b", obs(), P_NORM); end
`ifdef HAZ_PERF_CNT_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(mk(0, 0, 0, 0, 0, 0, 1, 0, P_FRZ));
            #1;
            n_cmp++;
            if (stall_cycles !== CW'(k)) begin n_bad++; $display("FAIL stall_count %0d: got %0d want %0d", k, stall_cycles, k); end
        end
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 1, P_NORM));
        #1;
        n_cmp++;
        if (stall_cycles !== CW'(4)) begin n_bad++; $display("FAIL stall_count_ack: got %0d want 4", stall_cycles); end
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, P_NORM));
        #1;
        n_cmp++;
        if (stall_cycles !== CW'(4)) begin n_bad++; $display("FAIL stall_count_hold: got %0d want 4", stall_cycles); end
`endif
    endtask

    task automatic test_random();
        bit         m_wait = 0;
        int         m_waited = 0;
        int         m_flush_left = 0;
        bit         m_terr = 0;
        int         m_cnt = 0;
        bit         lu;
        logic [5:0] e;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 199) == 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 6) == 0);
            dmem_req     = ($urandom_range(0, 3) == 0);
            dmem_ack     = 1'($urandom_range(0, 1));
            if ((cyc % 150) >= 100 && (cyc % 150) < 120) begin
                dmem_req = 1'b1;
                dmem_ack = 1'b0;
            end
            #1;
            if (rst) begin
                m_wait = 0; m_waited = 0; m_flush_left = 0; m_terr = 0; m_cnt = 0;
                e = P_OFF;
            end else begin
                lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
                e = P_NORM;
                if (m_wait) begin
                    e = P_FRZ;
                    if (dmem_ack || m_waited == MT - 1) e = P_NORM;
                end else if (dmem_req && !dmem_ack) e = P_FRZ;
                else if (m_flush_left > 0) e = P_FL;
                else if (branch_taken) e = P_BR;
                else if (lu) e = P_LU;
            end
            n_cmp++;
            if (obs() !== e || timeout_err !== m_terr) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %b/%b want %b/%b", cyc, obs(), timeout_err, e, m_terr);
            end
`ifdef HAZ_PERF_CNT_EN
            n_cmp++;
            if (stall_cycles !== CW'(m_cnt)) begin
                n_bad++; $display("FAIL random_stall_cycles cycle %0d: got %0d want %0d", cyc, stall_cycles, m_cnt);
            end
`endif
            if (!rst) begin
                if (e[5] == 1'b0 && m_cnt < (1 << CW) - 1) m_cnt++;
                if (m_wait) begin
                    if (dmem_ack) m_wait = 0;
                    else if (m_waited == MT - 1) begin m_wait = 0; m_terr = 1; end
                    else m_waited++;
                end else if (dmem_req && !dmem_ack) begin
                    m_wait = 1; m_waited = 0; m_flush_left = 0;
                end else if (m_flush_left > 0) m_flush_left--;
                else if (branch_taken) m_flush_left = FC - 1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_flush();
        test_mem_wait();
        test_timeout();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
